// File: rtl/conv3x3_featuremap_acc.sv
// conv3x3_featuremap_acc
//   One output feature map of a 3x3 "same"-padded convolution. CH_IN input
//   channels arrive packed on data_in, one pixel per transfer in raster order.
//   Per-channel 3x3 products are summed across channels, then shifted back to
//   FRAC_BITS, biased, optionally passed through leaky ReLU and saturated.
//   Weights and bias are runtime-loadable and are only written while IDLE.
//
// Ports
//   Clk, Rst     clock, synchronous active-high reset
//   data_in      CH_IN*DATA_WIDTH, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_in     data_in valid; transfer when valid_in && in_ready
//   in_ready     high in IDLE and RUN, low while the frame tail is flushed
//   w_wr_en      weight write strobe, address = channel*9 + row*3 + col
//   w_wr_addr    weight address
//   w_wr_data    weight value, also the bias value for b_wr_en
//   b_wr_en      bias write strobe
//   data_out     output pixel, valid with valid_out
//   valid_out    one cycle per output pixel
//   frame_done   pulse with the last valid_out of a frame
//   busy         high whenever the control FSM is not in IDLE
module conv3x3_featuremap_acc #(
   parameter int CH_IN      = 32,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int IMG_SIZE   = 104,
   parameter int LEAKY      = 1
) (
   input  logic                                Clk,
   input  logic                                Rst,
   input  logic [CH_IN*DATA_WIDTH-1:0]         data_in,
   input  logic                                valid_in,
   output logic                                in_ready,
   input  logic                                w_wr_en,
   input  logic [$clog2(CH_IN*9)-1:0]          w_wr_addr,
   input  logic [DATA_WIDTH-1:0]               w_wr_data,
   input  logic                                b_wr_en,
   output logic [DATA_WIDTH-1:0]               data_out,
   output logic                                valid_out,
   output logic                                frame_done,
   output logic                                busy
);

   localparam int NTAP  = 9 * CH_IN;
   localparam int WA_W  = $clog2(NTAP);
   localparam int ACC_W = 2 * DATA_WIDTH + $clog2(NTAP) + 1;
   localparam int PRD_W = 2 * DATA_WIDTH;
   localparam int NPIX  = IMG_SIZE * IMG_SIZE;
   localparam int POS_W = $clog2(NPIX + IMG_SIZE + 1);
   localparam int COL_W = $clog2(IMG_SIZE);
   localparam int PIX_W = CH_IN * DATA_WIDTH;

   localparam logic [POS_W-1:0] POS_LAST_IN   = POS_W'(NPIX - 1);
   localparam logic [POS_W-1:0] POS_LAST_FL   = POS_W'(NPIX + IMG_SIZE);
   localparam logic [POS_W-1:0] POS_FIRST_OUT = POS_W'(IMG_SIZE + 1);
   localparam logic [COL_W-1:0] IDX_LAST      = COL_W'(IMG_SIZE - 1);
   localparam logic [WA_W-1:0]  W_ADDR_END    = WA_W'(NTAP);

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // control
   state_t              state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [COL_W-1:0]    in_col_q, in_col_d;
   logic [COL_W-1:0]    out_r_q, out_r_d;
   logic [COL_W-1:0]    out_c_q, out_c_d;
   logic                advance;
   logic                emit;
   logic                last_emit;
   logic [PIX_W-1:0]    pix;

   // coefficients (not reset)
   logic signed [DATA_WIDTH-1:0] weight_q [NTAP];
   logic signed [DATA_WIDTH-1:0] weight_d [NTAP];
   logic signed [DATA_WIDTH-1:0] bias_q, bias_d;

   // line buffers and window
   logic [PIX_W-1:0]             lb1_mem [IMG_SIZE];
   logic [PIX_W-1:0]             lb2_mem [IMG_SIZE];
   logic [PIX_W-1:0]             lb1_rd, lb2_rd;
   logic signed [DATA_WIDTH-1:0] win_q [CH_IN][3][3];
   logic signed [DATA_WIDTH-1:0] win_d [CH_IN][3][3];
   logic [8:0]                   mask_q, mask_d;
   logic [2:0]                   row_ok, col_ok;
   logic                         win_vld_q, win_vld_d;
   logic                         win_last_q, win_last_d;

   // S1 products
   logic signed [PRD_W-1:0]      prod_q [CH_IN][9];
   logic signed [PRD_W-1:0]      prod_d [CH_IN][9];
   logic                         s1_vld_q, s1_vld_d;
   logic                         s1_last_q, s1_last_d;
   logic signed [DATA_WIDTH-1:0] s1_bias_q, s1_bias_d;

   // S2 sum
   logic signed [ACC_W-1:0]      acc_q, acc_d;
   logic                         s2_vld_q, s2_vld_d;
   logic                         s2_last_q, s2_last_d;
   logic signed [DATA_WIDTH-1:0] s2_bias_q, s2_bias_d;

   // S3 output
   logic signed [ACC_W-1:0]      shifted, biased, act;
   logic [DATA_WIDTH-1:0]        data_out_q, data_out_d;
   logic                         valid_out_q, valid_out_d;
   logic                         frame_done_q, frame_done_d;

   // ------------------------------------------------------------------
   // Control FSM. FLUSH feeds IMG_SIZE+1 zero pixels so the last row's
   // windows are formed; the arithmetic stages behind the window register
   // carry their own valids and coefficient copies, so they finish the tail
   // on their own while the FSM is already back in IDLE.
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      in_col_d = in_col_q;
      in_ready = 1'b0;
      advance  = 1'b0;
      pix      = '0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (valid_in) begin
               advance = 1'b1;
               pix     = data_in;
               state_d = RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            if (valid_in) begin
               advance = 1'b1;
               pix     = data_in;
               if (pos_q == POS_LAST_IN) state_d = FLUSH;
            end
         end
         FLUSH: begin
            advance = 1'b1;
            if (pos_q == POS_LAST_FL) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         pos_d    = pos_q + POS_W'(1);
         in_col_d = (in_col_q == IDX_LAST) ? '0 : in_col_q + COL_W'(1);
         if ((state_q == FLUSH) && (pos_q == POS_LAST_FL)) begin
            pos_d    = '0;
            in_col_d = '0;
         end
      end
   end

   // Output-centre tracking: the window centre lags the input by IMG_SIZE+1.
   always_comb begin
      emit      = advance && (pos_q >= POS_FIRST_OUT);
      last_emit = emit && (out_r_q == IDX_LAST) && (out_c_q == IDX_LAST);
      out_r_d   = out_r_q;
      out_c_d   = out_c_q;
      if (emit) begin
         if (out_c_q == IDX_LAST) begin
            out_c_d = '0;
            out_r_d = (out_r_q == IDX_LAST) ? '0 : out_r_q + COL_W'(1);
         end else begin
            out_c_d = out_c_q + COL_W'(1);
         end
      end

      // Taps outside the frame are masked by centre position, which also
      // hides the column wrap and any stale line-buffer contents.
      row_ok[0] = (out_r_q != '0);
      row_ok[1] = 1'b1;
      row_ok[2] = (out_r_q != IDX_LAST);
      col_ok[0] = (out_c_q != '0);
      col_ok[1] = 1'b1;
      col_ok[2] = (out_c_q != IDX_LAST);
      for (int unsigned i = 0; i < 3; i++) begin
         for (int unsigned j = 0; j < 3; j++) begin
            mask_d[i*3+j] = row_ok[i] & col_ok[j];
         end
      end
      win_vld_d  = emit;
      win_last_d = last_emit;
   end

   // Window: row 0 = two lines back, row 2 = newest; column 2 = newest.
   always_comb begin
      lb1_rd = lb1_mem[in_col_q];
      lb2_rd = lb2_mem[in_col_q];
      win_d  = win_q;
      if (advance) begin
         for (int unsigned k = 0; k < CH_IN; k++) begin
            for (int unsigned i = 0; i < 3; i++) begin
               win_d[k][i][0] = win_q[k][i][1];
               win_d[k][i][1] = win_q[k][i][2];
            end
            win_d[k][0][2] = lb2_rd[k*DATA_WIDTH +: DATA_WIDTH];
            win_d[k][1][2] = lb1_rd[k*DATA_WIDTH +: DATA_WIDTH];
            win_d[k][2][2] = pix[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      weight_d = weight_q;
      bias_d   = bias_q;
      if (state_q == IDLE) begin
         if (w_wr_en && (w_wr_addr < W_ADDR_END)) weight_d[w_wr_addr] = w_wr_data;
         if (b_wr_en) bias_d = w_wr_data;
      end
   end

   // S1: products; bias is sampled here too so an IDLE write cannot reach
   // outputs of the frame tail still in flight.
   always_comb begin
      for (int unsigned k = 0; k < CH_IN; k++) begin
         for (int unsigned t = 0; t < 9; t++) begin
            if (mask_q[t]) begin
               prod_d[k][t] = PRD_W'(win_q[k][t/3][t%3]) * PRD_W'(weight_q[k*9+t]);
            end else begin
               prod_d[k][t] = '0;
            end
         end
      end
      s1_vld_d  = win_vld_q;
      s1_last_d = win_last_q;
      s1_bias_d = bias_q;
   end

   // S2: full-width sum
   always_comb begin
      acc_d = '0;
      for (int unsigned k = 0; k < CH_IN; k++) begin
         for (int unsigned t = 0; t < 9; t++) begin
            acc_d = acc_d + ACC_W'(prod_q[k][t]);
         end
      end
      s2_vld_d  = s1_vld_q;
      s2_last_d = s1_last_q;
      s2_bias_d = s1_bias_q;
   end

   // S3: rescale, bias, activation, saturation
   always_comb begin
      shifted = acc_q >>> FRAC_BITS;
      biased  = shifted + ACC_W'(s2_bias_q);
      act     = biased;
      if ((LEAKY != 0) && biased[ACC_W-1]) act = biased >>> 3;
      data_out_d = data_out_q;
      if (s2_vld_q) begin
         if (act > SAT_MAX)      data_out_d = SAT_MAX[DATA_WIDTH-1:0];
         else if (act < SAT_MIN) data_out_d = SAT_MIN[DATA_WIDTH-1:0];
         else                    data_out_d = act[DATA_WIDTH-1:0];
      end
      valid_out_d  = s2_vld_q;
      frame_done_d = s2_vld_q & s2_last_q;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= IDLE;
         pos_q        <= '0;
         in_col_q     <= '0;
         out_r_q      <= '0;
         out_c_q      <= '0;
         win_vld_q    <= 1'b0;
         s1_vld_q     <= 1'b0;
         s2_vld_q     <= 1'b0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         in_col_q     <= in_col_d;
         out_r_q      <= out_r_d;
         out_c_q      <= out_c_d;
         win_vld_q    <= win_vld_d;
         s1_vld_q     <= s1_vld_d;
         s2_vld_q     <= s2_vld_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge Clk) begin
      weight_q   <= weight_d;
      bias_q     <= bias_d;
      win_q      <= win_d;
      mask_q     <= mask_d;
      win_last_q <= win_last_d;
      prod_q     <= prod_d;
      s1_last_q  <= s1_last_d;
      s1_bias_q  <= s1_bias_d;
      acc_q      <= acc_d;
      s2_last_q  <= s2_last_d;
      s2_bias_q  <= s2_bias_d;
   end

   always_ff @(posedge Clk) begin
      if (advance) begin
         lb1_mem[in_col_q] <= pix;
         lb2_mem[in_col_q] <= lb1_mem[in_col_q];
      end
   end

   assign data_out   = data_out_q;
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != IDLE);

endmodule
